// File: rtl/ca_8queen.sv
// N-queens solver: row-by-row backtracking search for the first solution in
// lexicographic order, then streams the board one one-hot row per cycle.
module ca_8queen #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         No_Answer,
  output logic         done,
  output logic [0:N-1] out_last
);

  typedef enum logic [2:0] {IDLE, SEARCH, OUT, FINISH, NOANS} state_t;

  localparam logic [3:0] N_CNT = 4'(N);
  localparam logic [3:0] LAST  = 4'(N - 1);

  state_t         state, state_nxt;
  logic [3:0]     row, row_nxt;
  logic [3:0]     col, col_nxt;
  logic [3:0]     kidx, kidx_nxt;
  logic [3*N-1:0] pos, pos_nxt;
  logic           done_nxt, no_ans_nxt, safe;
  logic [0:N-1]   out_nxt;

  function automatic logic [2:0] pos_at(input logic [3*N-1:0] p, input logic [3:0] idx);
    pos_at = 3'd0;
    for (int i = 0; i < N; i++)
      if (idx == 4'(i)) pos_at = p[3*i +: 3];
  endfunction

  function automatic logic [0:N-1] onehot(input logic [3:0] cidx);
    onehot = '0;
    for (int i = 0; i < N; i++)
      if (cidx == 4'(i)) onehot[i] = 1'b1;
  endfunction

  // Candidate is safe when no queen in an earlier row shares its column or diagonal.
  function automatic logic is_safe(input logic [3*N-1:0] p, input logic [3:0] r,
                                   input logic [3:0] c);
    int pk, cc, d;
    is_safe = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (4'(i) < r) begin
        pk = int'(p[3*i +: 3]);
        cc = int'(c);
        d  = (pk > cc) ? pk - cc : cc - pk;
        if (pk == cc || d == int'(r) - i) is_safe = 1'b0;
      end
    end
  endfunction

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    col_nxt    = col;
    kidx_nxt   = kidx;
    pos_nxt    = pos;
    done_nxt   = done;
    no_ans_nxt = No_Answer;
    out_nxt    = out_last;
    safe       = is_safe(pos, row, col);
    case (state)
      IDLE: begin
        done_nxt   = 1'b0;
        no_ans_nxt = 1'b0;
        out_nxt    = '0;
        if (start) begin
          row_nxt   = 4'd0;
          col_nxt   = 4'd0;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (col == N_CNT) begin
          if (row == 4'd0) begin
            state_nxt  = NOANS;
            no_ans_nxt = 1'b1;
          end else begin
            row_nxt = row - 4'd1;
            col_nxt = {1'b0, pos_at(pos, row - 4'd1)} + 4'd1;
          end
        end else if (safe) begin
          for (int i = 0; i < N; i++)
            if (row == 4'(i)) pos_nxt[3*i +: 3] = col[2:0];
          if (row == LAST) begin
            // Row 0 may be the one being written this cycle when N is 1.
            state_nxt = OUT;
            kidx_nxt  = 4'd0;
            done_nxt  = 1'b1;
            out_nxt   = onehot((row == 4'd0) ? col : {1'b0, pos_at(pos, 4'd0)});
          end else begin
            row_nxt = row + 4'd1;
            col_nxt = 4'd0;
          end
        end else begin
          col_nxt = col + 4'd1;
        end
      end
      OUT: begin
        if (kidx == LAST) begin
          state_nxt = FINISH;
        end else begin
          kidx_nxt = kidx + 4'd1;
          out_nxt  = onehot({1'b0, pos_at(pos, kidx + 4'd1)});
        end
      end
      FINISH: begin
        if (!start) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
          out_nxt   = '0;
        end
      end
      NOANS: begin
        if (!start) begin
          state_nxt  = IDLE;
          no_ans_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= 4'd0;
      col       <= 4'd0;
      kidx      <= 4'd0;
      pos       <= '0;
      done      <= 1'b0;
      No_Answer <= 1'b0;
      out_last  <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      kidx      <= kidx_nxt;
      pos       <= pos_nxt;
      done      <= done_nxt;
      No_Answer <= no_ans_nxt;
      out_last  <= out_nxt;
    end
  end

endmodule

// File: tb/tb_ca_8queen.sv
// Bench for ca_8queen: instances for N=8,4,3,1 checked against a backtracking
// reference model, the known first solutions, and per-cycle output invariants.
module tb_ca_8queen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, go;
  int   sel;
  logic start8, start4, start3, start1;
  logic na8, na4, na3, na1, d8, d4, d3, d1;
  logic [0:7] o8;
  logic [0:3] o4;
  logic [0:2] o3;
  logic [0:0] o1;
  logic       obs_done, obs_na;
  logic [0:7] obs_out;

  ca_8queen #(.N(8)) u8 (.clk(clk), .reset(reset), .start(start8), .No_Answer(na8), .done(d8), .out_last(o8));
  ca_8queen #(.N(4)) u4 (.clk(clk), .reset(reset), .start(start4), .No_Answer(na4), .done(d4), .out_last(o4));
  ca_8queen #(.N(3)) u3 (.clk(clk), .reset(reset), .start(start3), .No_Answer(na3), .done(d3), .out_last(o3));
  ca_8queen #(.N(1)) u1 (.clk(clk), .reset(reset), .start(start1), .No_Answer(na1), .done(d1), .out_last(o1));

  always_comb begin
    start8 = go && (sel == 8);
    start4 = go && (sel == 4);
    start3 = go && (sel == 3);
    start1 = go && (sel == 1);
    obs_done = 1'b0;
    obs_na   = 1'b0;
    obs_out  = '0;
    case (sel)
      8: begin obs_done = d8; obs_na = na8; obs_out = o8; end
      4: begin obs_done = d4; obs_na = na4; obs_out = {o4, 4'b0}; end
      3: begin obs_done = d3; obs_na = na3; obs_out = {o3, 5'b0}; end
      1: begin obs_done = d1; obs_na = na1; obs_out = {o1, 7'b0}; end
      default: ;
    endcase
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: spec's search rules executed on plain arrays, one step per SEARCH cycle.
  int m_cols[8];
  int m_cyc;
  bit m_found;
  task automatic model(input int n);
    int r, c;
    bit ok;
    r = 0; c = 0; m_cyc = 0; m_found = 0;
    for (int i = 0; i < 8; i++) m_cols[i] = 0;
    while (m_cyc < 100000) begin
      m_cyc++;
      if (c == n) begin
        if (r == 0) break;
        r--;
        c = m_cols[r] + 1;
      end else begin
        ok = 1;
        for (int k = 0; k < r; k++)
          if (m_cols[k] == c || (m_cols[k] > c ? m_cols[k] - c : c - m_cols[k]) == r - k) ok = 0;
        if (ok) begin
          m_cols[r] = c;
          if (r == n - 1) begin m_found = 1; break; end
          r++;
          c = 0;
        end else c++;
      end
    end
  endtask

  int cap[8];

  function automatic int col_of(input logic [0:7] v, input int n);
    col_of = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < n; i++) if (v[i]) col_of = i;
  endfunction

  function automatic bit legal(input int n);
    legal = 1;
    for (int i = 0; i < n; i++) begin
      if (cap[i] < 0 || cap[i] >= n) legal = 0;
      for (int j = i + 1; j < n; j++)
        if (cap[i] == cap[j] || (cap[i] > cap[j] ? cap[i] - cap[j] : cap[j] - cap[i]) == j - i)
          legal = 0;
    end
  endfunction

  // Starts instance n with start held, checks latency, stream and the held FINISH/NOANS state.
  task automatic run(input int n, output int cyc);
    model(n);
    sel = n;
    go  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!obs_done && !obs_na && cyc < 5000);
    check($sformatf("n%0d_latency", n), cyc, m_cyc + 1);
    check($sformatf("n%0d_no_answer", n), obs_na, !m_found);
    check($sformatf("n%0d_done", n), obs_done, m_found);
    if (m_found) begin
      for (int r = 0; r < n; r++) begin
        cap[r] = col_of(obs_out, n);
        check($sformatf("n%0d_row%0d", n, r), cap[r], m_cols[r]);
        check($sformatf("n%0d_row%0d_done", n, r), obs_done, 1);
        if (r < n - 1) @(negedge clk);
      end
      check($sformatf("n%0d_legal", n), legal(n), 1);
      repeat (3) begin
        @(negedge clk);
        check($sformatf("n%0d_hold_done", n), obs_done, 1);
        check($sformatf("n%0d_hold_row", n), col_of(obs_out, n), cap[n - 1]);
        check($sformatf("n%0d_hold_na", n), obs_na, 0);
      end
    end else begin
      repeat (3) begin
        @(negedge clk);
        check($sformatf("n%0d_noans_hold", n), obs_na, 1);
        check($sformatf("n%0d_noans_done", n), obs_done, 0);
        check($sformatf("n%0d_noans_out", n), obs_out, 0);
      end
    end
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_flags"}, {d8, na8, d4, na4, d3, na3, d1, na1}, 0);
    check({tag, "_outs"}, {o8, o4, o3, o1}, 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      compared++;
      assert (!(d8 && na8) && !(d4 && na4) && !(d3 && na3) && !(d1 && na1) &&
              (!d8 || $countones(o8) == 1) && (!d4 || $countones(o4) == 1) &&
              (!d3 || $countones(o3) == 1) && (!d1 || $countones(o1) == 1)) else begin
        mismatched++;
        $error("FAIL monitor observed=%b%b%b%b/%h_%h_%h_%h expected=exclusive flags and one-hot rows",
               d8, na8, d4, na4, o8, o4, o3, o1);
      end
    end
  end

  int exp8[8] = '{0, 4, 7, 5, 2, 6, 1, 3};
  int exp4[4] = '{1, 3, 0, 2};
  int cyc_first, cyc_again, wait_n;

  initial begin
    reset = 1'b0;
    go    = 1'b0;
    sel   = 0;
    #12;
    all_zero("reset_held");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    all_zero("idle_no_start");

    // N=8 with start held
    run(8, cyc_first);
    for (int r = 0; r < 8; r++) check($sformatf("n8_spec_row%0d", r), cap[r], exp8[r]);

    // FINISH -> IDLE on one low cycle of start, then same solution again
    go = 1'b0;
    @(negedge clk);
    check("finish_release_done", d8, 0);
    check("finish_release_out", o8, 0);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    run(8, cyc_again);
    check("n8_rerun_latency", cyc_again, cyc_first);
    for (int r = 0; r < 8; r++) check($sformatf("n8_rerun_row%0d", r), cap[r], exp8[r]);
    go = 1'b0;
    @(negedge clk);

    // N=3 has no solution; N=4 and N=1 stream
    run(3, cyc_again);
    go = 1'b0;
    @(negedge clk);
    check("n3_release_na", na3, 0);
    run(4, cyc_again);
    for (int r = 0; r < 4; r++) check($sformatf("n4_spec_row%0d", r), cap[r], exp4[r]);
    go = 1'b0;
    @(negedge clk);
    run(1, cyc_again);
    check("n1_row", o1, 1'b1);
    go = 1'b0;
    @(negedge clk);

    // Reset pulse at a random point inside the N=8 search
    model(8);
    sel = 8;
    go  = 1'b1;
    wait_n = int'($urandom_range(2, m_cyc - 2));
    repeat (wait_n) @(negedge clk);
    #2 reset = 1'b0;
    #1 all_zero("reset_mid_search");
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    run(8, cyc_again);
    check("n8_after_reset_latency", cyc_again, cyc_first);
    for (int r = 0; r < 8; r++) check($sformatf("n8_after_reset_row%0d", r), cap[r], exp8[r]);

    // Reset while streaming/finished clears outputs before any clock edge
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    wait_n = 0;
    while (!d8 && wait_n < 5000) begin
      @(negedge clk);
      wait_n++;
    end
    repeat ($urandom_range(1, 6)) @(negedge clk);
    #2 reset = 1'b0;
    #1 all_zero("reset_mid_stream");
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    all_zero("idle_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
